// File: rtl/button_input_reader_if.sv
// Signal bundle between the button conditioner and its user: raw pins and counter clear in,
// debounced levels, press/release strobes and packed per-channel press counts out.
interface button_input_reader_if #(
    parameter int NUM_BTN = 4
);
    logic [NUM_BTN-1:0]   BTN_RAW;
    logic                 CNT_CLR;
    logic [NUM_BTN-1:0]   BTN_LEVEL;
    logic [NUM_BTN-1:0]   BTN_PRESS;
    logic [NUM_BTN-1:0]   BTN_RELEASE;
    logic [NUM_BTN*8-1:0] PRESS_COUNT;

    modport master (
        output BTN_RAW,
        output CNT_CLR,
        input  BTN_LEVEL,
        input  BTN_PRESS,
        input  BTN_RELEASE,
        input  PRESS_COUNT
    );

    modport slave (
        input  BTN_RAW,
        input  CNT_CLR,
        output BTN_LEVEL,
        output BTN_PRESS,
        output BTN_RELEASE,
        output PRESS_COUNT
    );
endinterface

// File: rtl/button_input_reader.sv
// Per-channel push-button conditioner: 2-flop synchroniser, stable-count debounce,
// registered press/release strobes and an 8-bit wrapping press counter.
module button_input_reader #(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int BTN_ACTIVE_LOW  = 1
) (
    input logic                  CLK,
    input logic                  RST_N,
    button_input_reader_if.slave bus
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [NUM_BTN-1:0] IDLE_PIN = (BTN_ACTIVE_LOW != 0) ? '1 : '0;

    logic [NUM_BTN-1:0] sync1;
    logic [NUM_BTN-1:0] sync2;
    logic [NUM_BTN-1:0] samp;

    logic [NUM_BTN-1:0] level_q;
    logic [NUM_BTN-1:0] level_d;
    logic [NUM_BTN-1:0] press_q;
    logic [NUM_BTN-1:0] press_d;
    logic [NUM_BTN-1:0] release_q;
    logic [NUM_BTN-1:0] release_d;
    logic [CW-1:0]      cnt_q   [NUM_BTN];
    logic [CW-1:0]      cnt_d   [NUM_BTN];
    logic [7:0]         count_q [NUM_BTN];
    logic [7:0]         count_d [NUM_BTN];

    // Synchroniser resets to the idle pin level so reset release never looks like a press
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1 <= IDLE_PIN;
            sync2 <= IDLE_PIN;
        end else begin
            sync1 <= bus.BTN_RAW;
            sync2 <= sync1;
        end
    end

    always_comb begin
        samp = (BTN_ACTIVE_LOW != 0) ? ~sync2 : sync2;
    end

    always_comb begin
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        for (int unsigned i = 0; i < NUM_BTN; i++) begin
            cnt_d[i]   = '0;
            count_d[i] = count_q[i];
            if (samp[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    level_d[i]   = samp[i];
                    press_d[i]   = samp[i];
                    release_d[i] = ~samp[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
            // Clear takes priority over a press strobe arriving on the same cycle
            if (bus.CNT_CLR) begin
                count_d[i] = '0;
            end else if (press_q[i]) begin
                count_d[i] = count_q[i] + 8'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                cnt_q[i]   <= '0;
                count_q[i] <= '0;
            end
        end else begin
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                cnt_q[i]   <= cnt_d[i];
                count_q[i] <= count_d[i];
            end
        end
    end

    assign bus.BTN_LEVEL   = level_q;
    assign bus.BTN_PRESS   = press_q;
    assign bus.BTN_RELEASE = release_q;

    always_comb begin
        bus.PRESS_COUNT = '0;
        for (int unsigned i = 0; i < NUM_BTN; i++) begin
            bus.PRESS_COUNT[8*i +: 8] = count_q[i];
        end
    end
endmodule
